// File: rtl/store_trace_pkg.sv
// Shared constants and types for the store trace logger.
// STORE_TRACE_TIMESTAMP_EN adds a 32-bit capture timestamp to every entry.
package store_trace_pkg;

  localparam logic [31:0] PASS_ADDR_DEF = 32'd84;
  localparam logic [31:0] PASS_DATA_DEF = 32'd7;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  typedef struct packed {
`ifdef STORE_TRACE_TIMESTAMP_EN
    logic [31:0] stamp;
`endif
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign count   = count_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Gating with empty keeps the head at zero after reset without resetting storage.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: always_comb gives every output a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/store_trace_logger.sv
// Buffers CPU store events for a debug drain port and detects lab pass/fail.
// Build with STORE_TRACE_TIMESTAMP_EN to add per-entry capture timestamps (out_time).
module store_trace_logger
  import store_trace_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADDR = PASS_ADDR_DEF,
  parameter logic [31:0] PASS_DATA = PASS_DATA_DEF,
  parameter int          CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memwrite,
  input  logic [31:0]            dataadr,
  input  logic [31:0]            writedata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
`ifdef STORE_TRACE_TIMESTAMP_EN
  output logic [31:0]            out_time,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   pass,
  output logic                   fail,
  output logic [CNT_W-1:0]       store_cnt
);

  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  entry_t           wr_entry, rd_entry;
  logic             fifo_full, fifo_empty, pop;
  logic             overflow_q, overflow_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

`ifdef STORE_TRACE_TIMESTAMP_EN
  logic [31:0] time_q, time_d;

  assign time_d   = time_q + 32'd1;
  assign out_time = rd_entry.stamp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) time_q <= '0;
    else      time_q <= time_d;
  end
`endif

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = dataadr;
    wr_entry.data = writedata;
`ifdef STORE_TRACE_TIMESTAMP_EN
    wr_entry.stamp = time_q;
`endif
  end

  assign pop = out_valid & out_ready;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (memwrite),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign out_valid = ~fifo_empty;
  assign out_addr  = rd_entry.addr;
  assign out_data  = rd_entry.data;

  always_comb begin
    overflow_d  = overflow_q | (memwrite & fifo_full & ~pop);
    store_cnt_d = store_cnt_q;
    if (memwrite && (store_cnt_q != '1)) store_cnt_d = store_cnt_q + CNT_INC;

    // The result watcher ignores FIFO occupancy; only the first store to PASS_ADDR counts.
    state_d = state_q;
    if ((state_q == ST_IDLE) && memwrite && (dataadr == PASS_ADDR))
      state_d = (writedata == PASS_DATA) ? ST_PASS : ST_FAIL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      store_cnt_q <= '0;
      state_q     <= ST_IDLE;
    end else begin
      overflow_q  <= overflow_d;
      store_cnt_q <= store_cnt_d;
      state_q     <= state_d;
    end
  end

  assign overflow  = overflow_q;
  assign store_cnt = store_cnt_q;
  assign pass      = (state_q == ST_PASS);
  assign fail      = (state_q == ST_FAIL);

endmodule

// File: doc/store_trace_logger.md
Name: store_trace_logger

Overview:
- Sits directly downstream of the single-cycle CPU top level.
- Consumes the CPU data-memory store port (memwrite, dataadr, writedata) and buffers every store event in a small FIFO.
- A bench or debug UART drains the FIFO through a valid/ready port.
- Also runs the lab pass/fail detector: a store of PASS_DATA to PASS_ADDR means the program succeeded; any other data to that address means it failed.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
PASS_ADDR, 32'd84, watched store address.
PASS_DATA, 32'd7, data value that signals success.
CNT_W, 16, width of the store counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
memwrite  input  1  CPU store strobe; one store per cycle while high.
dataadr  input  32  CPU store byte address.
writedata  input  32  CPU store data.
out_valid  output  1  FIFO head entry is valid.
out_ready  input  1  consumer accepts the head entry this cycle.
out_addr  output  32  head entry address.
out_data  output  32  head entry data.
count  output  $clog2(DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky; a store was dropped because the FIFO was full.
pass  output  1  sticky; PASS_DATA was stored to PASS_ADDR.
fail  output  1  sticky; other data was stored to PASS_ADDR.
store_cnt  output  CNT_W  total stores seen, saturating.

Behaviour:
- Reset (rst=0, async), all outputs cleared:
  - out_valid=0, count=0, overflow=0, pass=0, fail=0, store_cnt=0.
  - out_addr and out_data read 0.
  - Read and write pointers cleared.
- Capture:
  - Sampled on the rising clk edge when memwrite=1. The CPU holds the store stable for the whole cycle; its data memory writes on ~clk.
  - Push = memwrite. Entry = {dataadr, writedata}.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0).
  - out_addr and out_data show the head entry combinationally from storage.
  - Push latency: the entry is visible on out_* the cycle after the capturing edge.
- Pop = out_valid & out_ready. out_ready while empty is ignored.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - This is legal when full, so no drop occurs.
- Push while full without pop:
  - The entry is dropped and FIFO contents are unchanged.
  - overflow is set and holds until reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count distinguishes full from empty.
- store_cnt increments on every memwrite cycle, including dropped stores, and saturates at all-ones.
- Result FSM, states IDLE, PASS, FAIL; pass = (state==PASS), fail = (state==FAIL):
  - IDLE -> PASS when memwrite & dataadr==PASS_ADDR & writedata==PASS_DATA.
  - IDLE -> FAIL when memwrite & dataadr==PASS_ADDR & writedata!=PASS_DATA.
  - PASS and FAIL are terminal until reset.
  - FSM evaluation is independent of FIFO full state.
- Reset mid-operation: all state is lost immediately. The first edge after rst rises acts on a clean FIFO.

Optional Feature:
- Macro: STORE_TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter is added, reset to 0 and wrapping.
  - Each FIFO entry also stores the counter value at capture.
  - Extra output port out_time [31:0] presents the head entry timestamp.
- Undefined:
  - No counter, no out_time port.
  - Entry width is 64 bits.

Decomposition:
- Shared package store_trace_pkg holds:
  - Default PASS_ADDR/PASS_DATA constants.
  - Result-state encoding (IDLE=2'b00, PASS=2'b01, FAIL=2'b10).
  - Entry-width constant derived from STORE_TRACE_TIMESTAMP_EN.
- One sub-module, trace_fifo: parameterised width/depth FWFT FIFO with push/pop/full/empty/count.
- Capture, counter and FSM logic stay in store_trace_logger.

Test Plan:
1. Reset then 3 stores (addr 0x10/0x14/0x18, data 1/2/3), out_ready=0 -> count=3, head shows {0x10,1}. Raising out_ready pops in order over 3 cycles, then out_valid=0.
2. 9 consecutive stores, DEPTH=8, out_ready=0 -> count=8, overflow=1, store_cnt=9. Draining yields the first 8 entries only.
3. FIFO full and memwrite=1 with out_ready=1 in the same cycle -> count stays 8, overflow stays 0, new entry becomes the tail.
4. Store data 7 to addr 84 -> pass=1 next cycle. A later store of 5 to addr 84 leaves pass=1, fail=0.
5. From reset, store 5 to addr 84 -> fail=1. Assert rst=0 mid-stream -> every output is 0 asynchronously before the next edge.
6. With STORE_TRACE_TIMESTAMP_EN, stores at cycles 3 and 10 after reset -> out_time reads 3 then 10 as entries pop.
